// File: rtl/thread_join_tracker.sv
// Join side of a fork/join scheme: tracks outstanding worker threads, folds in
// completion events and reports when the join_all / join_any condition is met.
module thread_join_tracker #(
  parameter int NUM_THREADS = 4,
  parameter int TS_W        = 16,
  localparam int ID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fork_valid,
  output logic                   fork_ready,
  input  logic [NUM_THREADS-1:0] fork_mask,
  input  logic [1:0]             fork_mode,
  input  logic                   done_valid,
  input  logic [ID_W-1:0]        done_id,
  output logic                   join_valid,
  input  logic                   join_ready,
  output logic [NUM_THREADS-1:0] join_mask,
  output logic [TS_W-1:0]        join_elapsed,
  output logic                   busy,
  output logic                   err_spurious,
  output logic                   err_overlap
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_REPORT = 2'b10
  } state_t;

  localparam logic [1:0]      MODE_ANY  = 2'b01;
  localparam logic [1:0]      MODE_NONE = 2'b10;
  localparam logic [TS_W-1:0] CNT_MAX   = '1;

  function automatic logic [TS_W-1:0] sat_inc(input logic [TS_W-1:0] v);
    return (v == CNT_MAX) ? v : v + TS_W'(1);
  endfunction

  state_t                 state_q, state_d;
  logic [NUM_THREADS-1:0] pend_q, pend_d;
  logic [NUM_THREADS-1:0] trk_q, trk_d;
  logic [NUM_THREADS-1:0] cmp_q, cmp_d;
  logic [TS_W-1:0]        cnt_q, cnt_d;
  logic                   any_q, any_d;
  logic                   join_valid_q, join_valid_d;
  logic [NUM_THREADS-1:0] join_mask_q, join_mask_d;
  logic [TS_W-1:0]        join_elapsed_q, join_elapsed_d;
  logic                   busy_q, busy_d;
  logic                   err_spurious_q, err_spurious_d;
  logic                   err_overlap_q, err_overlap_d;

  logic [NUM_THREADS-1:0] done_hit;
  logic [NUM_THREADS-1:0] done_clr;
  logic [NUM_THREADS-1:0] cmp_next;
  logic                   join_met;

  // Decoding by comparison means an out-of-range id simply hits nothing.
  always_comb begin
    done_hit = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      done_hit[i] = done_valid && (done_id == ID_W'(i));
    end
  end

  assign done_clr = done_hit & pend_q;
  assign cmp_next = cmp_q | (done_clr & trk_q);
  assign join_met = any_q ? (|(trk_q & cmp_next)) : ~(|(trk_q & ~cmp_next));

  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q & ~done_clr;
    trk_d          = trk_q;
    cmp_d          = cmp_next;
    cnt_d          = cnt_q;
    any_d          = any_q;
    join_valid_d   = join_valid_q;
    join_mask_d    = join_mask_q;
    join_elapsed_d = join_elapsed_q;
    err_overlap_d  = 1'b0;
    err_spurious_d = done_valid && ~(|done_clr);

    case (state_q)
      S_IDLE: begin
        if (fork_valid) begin
          if (|(fork_mask & pend_q)) begin
            err_overlap_d = 1'b1;
          end else begin
            pend_d = pend_d | fork_mask;
            if ((fork_mask == '0) || (fork_mode == MODE_NONE)) begin
              state_d        = S_REPORT;
              join_valid_d   = 1'b1;
              join_mask_d    = '0;
              join_elapsed_d = '0;
            end else begin
              state_d = S_WAIT;
              trk_d   = fork_mask;
              cmp_d   = '0;
              cnt_d   = '0;
              any_d   = (fork_mode == MODE_ANY);
            end
          end
        end
      end
      S_WAIT: begin
        cnt_d = sat_inc(cnt_q);
        // cnt counts the accept cycle as 0, so this cycle's elapsed is cnt+1.
        if (join_met) begin
          state_d        = S_REPORT;
          join_valid_d   = 1'b1;
          join_mask_d    = cmp_next;
          join_elapsed_d = sat_inc(cnt_q);
        end
      end
      S_REPORT: begin
        if (join_ready) begin
          state_d      = S_IDLE;
          join_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = |pend_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pend_q         <= '0;
      trk_q          <= '0;
      cmp_q          <= '0;
      cnt_q          <= '0;
      any_q          <= 1'b0;
      join_valid_q   <= 1'b0;
      join_mask_q    <= '0;
      join_elapsed_q <= '0;
      busy_q         <= 1'b0;
      err_spurious_q <= 1'b0;
      err_overlap_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      trk_q          <= trk_d;
      cmp_q          <= cmp_d;
      cnt_q          <= cnt_d;
      any_q          <= any_d;
      join_valid_q   <= join_valid_d;
      join_mask_q    <= join_mask_d;
      join_elapsed_q <= join_elapsed_d;
      busy_q         <= busy_d;
      err_spurious_q <= err_spurious_d;
      err_overlap_q  <= err_overlap_d;
    end
  end

  assign fork_ready   = (state_q == S_IDLE);
  assign join_valid   = join_valid_q;
  assign join_mask    = join_mask_q;
  assign join_elapsed = join_elapsed_q;
  assign busy         = busy_q;
  assign err_spurious = err_spurious_q;
  assign err_overlap  = err_overlap_q;

endmodule

// File: tb/tb_thread_join_tracker.sv
// Bench for thread_join_tracker: directed scenarios plus random traffic, checked
// against a transaction-level model (per-thread completion times since fork).
module tb_thread_join_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        fork_valid;
  logic        fork_ready;
  logic [3:0]  fork_mask;
  logic [1:0]  fork_mode;
  logic        done_valid;
  logic [1:0]  done_id;
  logic        join_valid;
  logic        join_ready;
  logic [3:0]  join_mask;
  logic [15:0] join_elapsed;
  logic        busy;
  logic        err_spurious;
  logic        err_overlap;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: phase 0 idle, 1 waiting for join, 2 reporting.
  int       m_phase;
  bit [3:0] m_pend;
  bit [3:0] m_trk;
  bit       m_any;
  int       m_t0;
  int       m_done_at[4];
  bit [3:0] m_jmask;
  int       m_jel;
  bit       m_spur;
  bit       m_ovl;

  thread_join_tracker #(.NUM_THREADS(4), .TS_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .fork_valid   (fork_valid),
    .fork_ready   (fork_ready),
    .fork_mask    (fork_mask),
    .fork_mode    (fork_mode),
    .done_valid   (done_valid),
    .done_id      (done_id),
    .join_valid   (join_valid),
    .join_ready   (join_ready),
    .join_mask    (join_mask),
    .join_elapsed (join_elapsed),
    .busy         (busy),
    .err_spurious (err_spurious),
    .err_overlap  (err_overlap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pend  = '0;
    m_trk   = '0;
    m_any   = 1'b0;
    m_t0    = 0;
    m_jmask = '0;
    m_jel   = 0;
    m_spur  = 1'b0;
    m_ovl   = 1'b0;
    for (int i = 0; i < 4; i++) m_done_at[i] = -1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_fork_ready"}, 32'(fork_ready), 32'(m_phase == 0));
    check({tag, "_join_valid"}, 32'(join_valid), 32'(m_phase == 2));
    check({tag, "_join_mask"}, 32'(join_mask), 32'(m_jmask));
    check({tag, "_join_elapsed"}, 32'(join_elapsed), 32'(m_jel));
    check({tag, "_busy"}, 32'(busy), 32'(m_pend != 0));
    check({tag, "_err_spurious"}, 32'(err_spurious), 32'(m_spur));
    check({tag, "_err_overlap"}, 32'(err_overlap), 32'(m_ovl));
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model
  // across the next rising edge, then compare at the following falling edge.
  task automatic tick(input bit fv, input bit [3:0] fm, input bit [1:0] fmd,
                      input bit dv, input bit [1:0] did, input bit jr);
    bit       legal;
    bit [3:0] old_pend;
    bit [3:0] dmask;
    int       el;
    fork_valid = fv;
    fork_mask  = fm;
    fork_mode  = fmd;
    done_valid = dv;
    done_id    = did;
    join_ready = jr;
    check("pre_fork_ready", 32'(fork_ready), 32'(m_phase == 0));

    old_pend = m_pend;
    legal    = dv && m_pend[did];
    m_spur   = dv && !legal;
    m_ovl    = 1'b0;
    if (legal) begin
      m_pend[did] = 1'b0;
      if (m_phase == 1 && m_trk[did]) m_done_at[did] = cyc - m_t0;
    end

    case (m_phase)
      0: begin
        if (fv) begin
          if ((fm & old_pend) != 0) begin
            m_ovl = 1'b1;
          end else begin
            m_pend = m_pend | fm;
            if (fm == 0 || fmd == 2'd2) begin
              m_phase = 2;
              m_jmask = '0;
              m_jel   = 0;
            end else begin
              m_phase = 1;
              m_t0    = cyc;
              m_trk   = fm;
              m_any   = (fmd == 2'd1);
              for (int i = 0; i < 4; i++) m_done_at[i] = -1;
            end
          end
        end
      end
      1: begin
        dmask = '0;
        for (int i = 0; i < 4; i++) if (m_trk[i] && m_done_at[i] >= 0) dmask[i] = 1'b1;
        if (m_any ? (dmask != 0) : (dmask == m_trk)) begin
          el      = cyc - m_t0;
          m_phase = 2;
          m_jmask = dmask;
          m_jel   = (el > 65535) ? 65535 : el;
        end
      end
      default: begin
        if (jr) m_phase = 0;
      end
    endcase

    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs("cyc");
    fork_valid = 1'b0;
    done_valid = 1'b0;
  endtask

  task automatic idle(input int n, input bit jr);
    for (int i = 0; i < n; i++) tick(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, jr);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    fork_valid = 1'b0;
    fork_mask  = '0;
    fork_mode  = '0;
    done_valid = 1'b0;
    done_id    = '0;
    join_ready = 1'b0;
    model_reset();
    #3;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // join_none, mask 0011
    tick(1'b1, 4'b0011, 2'd2, 1'b0, 2'd0, 1'b1);
    check("t1_join_valid", 32'(join_valid), 32'd1);
    check("t1_elapsed", 32'(join_elapsed), 32'd0);
    idle(19, 1'b1);
    tick(1'b0, 4'd0, 2'd0, 1'b1, 2'd0, 1'b1);
    idle(9, 1'b1);
    check("t1_busy_before", 32'(busy), 32'd1);
    tick(1'b0, 4'd0, 2'd0, 1'b1, 2'd1, 1'b1);
    check("t1_busy_after", 32'(busy), 32'd0);

    // join_all, mask 0011
    tick(1'b1, 4'b0011, 2'd0, 1'b0, 2'd0, 1'b0);
    idle(19, 1'b0);
    tick(1'b0, 4'd0, 2'd0, 1'b1, 2'd0, 1'b0);
    idle(9, 1'b0);
    check("t2_not_yet", 32'(join_valid), 32'd0);
    tick(1'b0, 4'd0, 2'd0, 1'b1, 2'd1, 1'b0);
    check("t2_join_valid", 32'(join_valid), 32'd1);
    check("t2_elapsed", 32'(join_elapsed), 32'd30);
    check("t2_mask", 32'(join_mask), 32'h3);
    tick(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b1);

    // join_any, mask 0110
    tick(1'b1, 4'b0110, 2'd1, 1'b0, 2'd0, 1'b0);
    idle(4, 1'b0);
    tick(1'b0, 4'd0, 2'd0, 1'b1, 2'd2, 1'b0);
    check("t3_elapsed", 32'(join_elapsed), 32'd5);
    check("t3_mask", 32'(join_mask), 32'h4);
    check("t3_busy", 32'(busy), 32'd1);
    tick(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b1);
    idle(5, 1'b0);
    tick(1'b0, 4'd0, 2'd0, 1'b1, 2'd1, 1'b0);
    check("t3_busy_after", 32'(busy), 32'd0);
    check("t3_no_spurious", 32'(err_spurious), 32'd0);

    // Overlap and spurious
    tick(1'b1, 4'b0001, 2'd2, 1'b0, 2'd0, 1'b1);
    idle(1, 1'b1);
    tick(1'b1, 4'b0011, 2'd0, 1'b0, 2'd0, 1'b0);
    check("t4_overlap", 32'(err_overlap), 32'd1);
    check("t4_idle", 32'(fork_ready), 32'd1);
    tick(1'b0, 4'd0, 2'd0, 1'b1, 2'd3, 1'b0);
    check("t4_spurious", 32'(err_spurious), 32'd1);
    check("t4_overlap_pulse", 32'(err_overlap), 32'd0);
    tick(1'b0, 4'd0, 2'd0, 1'b1, 2'd0, 1'b0);
    check("t4_busy", 32'(busy), 32'd0);

    // Back-pressure on the report
    tick(1'b1, 4'b1000, 2'd0, 1'b0, 2'd0, 1'b0);
    idle(3, 1'b0);
    tick(1'b0, 4'd0, 2'd0, 1'b1, 2'd3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", 32'(join_valid), 32'd1);
      check("t5_hold_elapsed", 32'(join_elapsed), 32'd4);
      check("t5_hold_mask", 32'(join_mask), 32'h8);
      check("t5_hold_fork_ready", 32'(fork_ready), 32'd0);
      idle(1, 1'b0);
    end
    tick(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b1);
    check("t5_released", 32'(fork_ready), 32'd1);

    // Reset mid-WAIT
    tick(1'b1, 4'b1111, 2'd0, 1'b0, 2'd0, 1'b0);
    tick(1'b0, 4'd0, 2'd0, 1'b1, 2'd0, 1'b0);
    tick(1'b0, 4'd0, 2'd0, 1'b1, 2'd1, 1'b0);
    async_reset();
    tick(1'b0, 4'd0, 2'd0, 1'b1, 2'd3, 1'b0);
    check("t6_spurious", 32'(err_spurious), 32'd1);

    // Random traffic, with simultaneous fork/done/handshake events
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 4) == 0, 4'($urandom), 2'($urandom),
           ($urandom % 3) != 0, 2'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/thread_join_tracker.md
Name: thread_join_tracker

Overview:
- Hardware join side of a fork/join thread scheme. An upstream dispatcher forks a set of worker threads, given as a bitmask, with a join mode.
- This block tracks outstanding threads, consumes their completion events, and reports when the join condition (all, any, none) is met.
- The report carries the elapsed cycle count and the completed-thread mask.
- Sits between the task dispatcher and the worker pool's completion bus.

Parameters:
NUM_THREADS, 4, number of trackable threads; one bit per thread in all masks
TS_W, 16, width of elapsed-cycle counter
ID_W, $clog2(NUM_THREADS), width of thread id (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
fork_valid  in  1  fork request valid
fork_ready  out  1  fork request accepted when valid&ready
fork_mask  in  NUM_THREADS  threads launched by this fork
fork_mode  in  2  00 join_all, 01 join_any, 10 join_none, 11 reserved (treated as join_all)
done_valid  in  1  completion event, single cycle, always accepted
done_id  in  ID_W  id of completing thread
join_valid  out  1  join report valid, held until join_ready
join_ready  in  1  consumer accepts report
join_mask  out  NUM_THREADS  tracked threads completed at join time
join_elapsed  out  TS_W  cycles from fork accept to join condition
busy  out  1  any thread outstanding (pend != 0)
err_spurious  out  1  one-cycle pulse: done for a non-pending thread
err_overlap  out  1  one-cycle pulse: fork mask overlaps pending threads

Behaviour:
- Reset (async, immediate):
  - state=IDLE; pend, trk, cmp, cnt, join_mask and join_elapsed all 0.
  - join_valid, busy, err_* = 0; fork_ready = 1.
- Registers:
  - pend = outstanding threads (persists across joins).
  - trk = threads of the current fork.
  - cmp = completed subset of trk.
  - cnt = elapsed counter.
- fork_ready = (state==IDLE). Combinational from state only.
- Fork accept in IDLE:
  - Mask overlaps pend: fork dropped; err_overlap pulses next cycle; stay IDLE.
  - fork_mask==0, any mode: go to REPORT; join_mask=0; join_elapsed=0.
  - join_none: pend|=mask; go to REPORT; join_mask=0; join_elapsed=0.
  - join_all / join_any: pend|=mask; trk=mask; cmp=0; cnt=0; go to WAIT.
- Done event, accepted in every state:
  - Legal when done_id<NUM_THREADS and pend[done_id]=1. Clears pend[done_id]; sets cmp[done_id] if trk[done_id].
  - Otherwise no state change; err_spurious pulses next cycle.
  - A done for a thread in the same cycle as the fork accept that launches it is spurious (pend not yet set).
- WAIT:
  - cnt increments every cycle, saturating at 2^TS_W-1.
  - Condition is evaluated with the current cycle's done folded in (cmp_next):
    - join_all: trk & ~cmp_next == 0.
    - join_any: trk & cmp_next != 0.
  - When the condition is met:
    - Next cycle: state=REPORT, join_valid=1.
    - join_mask = cmp_next.
    - join_elapsed = cnt+1 (cnt already counts the accept cycle as 0).
    - Net effect: a done arriving N cycles after the fork accept reports join_elapsed=N.
- REPORT:
  - join_valid held, outputs stable until join_valid&join_ready, then IDLE.
  - Dones keep updating pend; they do not alter join_mask.
- join_any: threads of trk still unfinished remain in pend; their later dones are legal and clear pend only.
- busy = |pend, registered.
- Mid-operation reset: all tracking lost; a post-reset done for a pre-reset thread is spurious.
- Simultaneous events:
  - Fork accept and done in the same cycle are both processed.
  - Join handshake and done in the same cycle are both processed.

Test Plan:
- Fork join_none, mask 0011; dones for id0 at +20, id1 at +30.
  - Expected: join_valid 1 cycle after accept, elapsed 0, mask 0000.
  - busy drops the cycle after the id1 done; no errors.
- Fork join_all, mask 0011; done id0 at +20, id1 at +30.
  - Expected: join_valid at +31, join_elapsed=30, join_mask=0011.
- Fork join_any, mask 0110; done id2 at +5, id1 at +12.
  - Expected: report elapsed=5, mask 0100; busy stays 1 until the id1 done; no error.
- Overlap and spurious events:
  - join_none mask 0001, then fork mask 0011 before id0 completes → err_overlap pulse, state IDLE, pend=0001.
  - done id3 while not pending → err_spurious pulse.
- Back-pressure: join_all mask 1000, done at +4, join_ready held low 10 cycles.
  - Expected: join_valid/mask/elapsed=4 stable; fork_ready=0 until the handshake.
- Reset in WAIT with mask 1111 after 2 dones.
  - Expected: immediately all outputs reset, fork_ready=1; subsequent done id3 → err_spurious.
